// File: rtl/io_port_pkg.sv
// Shared types and constants for the DMA io_* port endpoint.
package io_port_pkg;

  localparam int unsigned IO_SZ     = 8;
  localparam int unsigned IO_WSZ    = 8;
  // The DMA io queue is 4 deep with a 2-bit pointer.
  localparam int unsigned MAX_BURST = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDone  = 2'd2
  } io_tx_state_t;

  typedef struct packed {
    logic [IO_SZ-1:0]  addr;
    logic [IO_WSZ-1:0] data;
  } io_beat_t;

endpackage

// File: rtl/io_rx_fifo.sv
// Receive FIFO for DMA pushes; drops on full and flags a sticky overflow.
module io_rx_fifo #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned Depth = 4
) (
  input  logic          io_clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          overflow
);

  localparam int unsigned IW = $clog2(Depth);
  localparam int unsigned PW = IW + 1;

  logic [AW+DW-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             empty, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push & (~full | do_pop);

  assign valid     = ~empty;
  assign head_addr = empty ? '0 : mem_q[rd_ptr_q[IW-1:0]][AW+DW-1:DW];
  assign head_data = empty ? '0 : mem_q[rd_ptr_q[IW-1:0]][DW-1:0];

  always_ff @(posedge io_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge io_clk) begin
    if (do_push) mem_q[wr_ptr_q[IW-1:0]] <= {push_addr, push_data};
  end

endmodule

// File: rtl/io_port_endpoint.sv
// Peripheral-side endpoint of the DMA io_* port: tx burst FSM, staging slots, bus tristate,
// and the receive FIFO for DMA pushes.
module io_port_endpoint
  import io_port_pkg::*;
#(
  parameter int unsigned SZ       = 8,
  parameter int unsigned WSZ      = 8,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic           io_clk,
  input  logic           rst,
  input  logic           io_rx_interrupt,
  output logic           io_tx_interrupt,
  output logic           io_w_notr,
  inout  wire  [SZ-1:0]  io_addr,
  inout  wire  [WSZ-1:0] io_data,
  input  logic           tx_wr_en,
  input  logic [1:0]     tx_wr_idx,
  input  logic [WSZ-1:0] tx_wr_data,
  input  logic           tx_start,
  input  logic [SZ-1:0]  tx_base_addr,
  input  logic [2:0]     tx_len,
  output logic           tx_busy,
  output logic           tx_done,
  output logic           tx_err,
  output logic           rx_valid,
  output logic [SZ-1:0]  rx_addr,
  output logic [WSZ-1:0] rx_data,
  input  logic           rx_ready,
  output logic           rx_overflow
);

  io_tx_state_t   state_q, state_d;
  logic [SZ-1:0]  base_q, base_d;
  logic [2:0]     len_q, len_d;
  logic [1:0]     idx_q, idx_d;
  logic           err_q, err_d;
  logic [WSZ-1:0] stage_q [MAX_BURST];

  logic           len_ok, last_beat, rx_full;
  logic [SZ-1:0]  beat_addr;
  logic [WSZ-1:0] beat_data;

  assign len_ok    = (tx_len != 3'd0) && (tx_len <= 3'(MAX_BURST));
  assign last_beat = ({1'b0, idx_q} == (len_q - 3'd1));
  assign beat_addr = base_q + SZ'(idx_q);
  assign beat_data = stage_q[idx_q];

  // DMA push always owns the bus; our beat simply waits.
  assign io_w_notr       = (state_q == StBurst) & ~io_rx_interrupt;
  assign io_tx_interrupt = io_w_notr & last_beat;
  assign io_addr         = io_w_notr ? beat_addr : {SZ{1'bz}};
  assign io_data         = io_w_notr ? beat_data : {WSZ{1'bz}};

  assign tx_busy = (state_q != StIdle);
  assign tx_done = (state_q == StDone);
  assign tx_err  = err_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          if (len_ok) begin
            base_d  = tx_base_addr;
            len_d   = tx_len;
            idx_d   = 2'd0;
            state_d = StBurst;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StBurst: begin
        if (io_w_notr) begin
          if (last_beat) state_d = StDone;
          else           idx_d   = idx_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge io_clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Staging is deliberately not reset and is frozen outside idle.
  always_ff @(posedge io_clk) begin
    if (tx_wr_en && (state_q == StIdle)) stage_q[tx_wr_idx] <= tx_wr_data;
  end

  io_rx_fifo #(
    .AW    (SZ),
    .DW    (WSZ),
    .Depth (RX_DEPTH)
  ) u_rx_fifo (
    .io_clk    (io_clk),
    .rst       (rst),
    .push      (io_rx_interrupt),
    .push_addr (io_addr),
    .push_data (io_data),
    .pop       (rx_ready),
    .valid     (rx_valid),
    .head_addr (rx_addr),
    .head_data (rx_data),
    .full      (rx_full),
    .overflow  (rx_overflow)
  );

  logic unused_full;
  assign unused_full = rx_full;

endmodule

// File: tb/tb_io_port_endpoint.sv
// Directed self-checking bench for io_port_endpoint.
module tb_io_port_endpoint;

  logic       io_clk = 1'b0;
  logic       rst = 1'b0;
  logic       io_rx_interrupt = 1'b0;
  logic       io_tx_interrupt, io_w_notr;
  wire  [7:0] io_addr, io_data;
  logic [7:0] dma_addr = '0, dma_data = '0;
  logic       tx_wr_en = 1'b0;
  logic [1:0] tx_wr_idx = '0;
  logic [7:0] tx_wr_data = '0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_base_addr = '0;
  logic [2:0] tx_len = '0;
  logic       tx_busy, tx_done, tx_err;
  logic       rx_valid, rx_ready = 1'b0, rx_overflow;
  logic [7:0] rx_addr, rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  assign io_addr = io_rx_interrupt ? dma_addr : 8'bz;
  assign io_data = io_rx_interrupt ? dma_data : 8'bz;

  always #5 io_clk = ~io_clk;

  io_port_endpoint #(.SZ(8), .WSZ(8), .RX_DEPTH(4)) dut (
    .io_clk          (io_clk),
    .rst             (rst),
    .io_rx_interrupt (io_rx_interrupt),
    .io_tx_interrupt (io_tx_interrupt),
    .io_w_notr       (io_w_notr),
    .io_addr         (io_addr),
    .io_data         (io_data),
    .tx_wr_en        (tx_wr_en),
    .tx_wr_idx       (tx_wr_idx),
    .tx_wr_data      (tx_wr_data),
    .tx_start        (tx_start),
    .tx_base_addr    (tx_base_addr),
    .tx_len          (tx_len),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done),
    .tx_err          (tx_err),
    .rx_valid        (rx_valid),
    .rx_addr         (rx_addr),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .rx_overflow     (rx_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick();
    @(negedge io_clk);
    #1;
  endtask

  task automatic write_slot(input logic [1:0] idx, input logic [7:0] data);
    tx_wr_en = 1'b1; tx_wr_idx = idx; tx_wr_data = data;
    tick();
    tx_wr_en = 1'b0;
  endtask

  task automatic start(input logic [7:0] base, input logic [2:0] len);
    tx_start = 1'b1; tx_base_addr = base; tx_len = len;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] a, input logic [7:0] d,
                      input logic last);
    check({tag, " w_notr"}, 32'(io_w_notr), 32'd1);
    check({tag, " addr"}, 32'(io_addr), 32'(a));
    check({tag, " data"}, 32'(io_data), 32'(d));
    check({tag, " tx_int"}, 32'(io_tx_interrupt), 32'(last));
  endtask

  task automatic rx_push(input logic [7:0] a, input logic [7:0] d);
    io_rx_interrupt = 1'b1; dma_addr = a; dma_data = d;
    tick();
    io_rx_interrupt = 1'b0;
  endtask

  task automatic rx_head(input string tag, input logic [7:0] a, input logic [7:0] d);
    check({tag, " valid"}, 32'(rx_valid), 32'd1);
    check({tag, " addr"}, 32'(rx_addr), 32'(a));
    check({tag, " data"}, 32'(rx_data), 32'(d));
  endtask

  initial begin
    logic [7:0] slots [4];
    slots[0] = 8'h11; slots[1] = 8'h22; slots[2] = 8'h33; slots[3] = 8'h44;

    // Reset state
    tick();
    check("rst w_notr", 32'(io_w_notr), 32'd0);
    check("rst busy", 32'(tx_busy), 32'd0);
    check("rst done", 32'(tx_done), 32'd0);
    check("rst err", 32'(tx_err), 32'd0);
    check("rst rx_valid", 32'(rx_valid), 32'd0);
    check("rst ovf", 32'(rx_overflow), 32'd0);
    rst = 1'b1;
    tick();

    // 1: single beat
    write_slot(2'd0, 8'hA5);
    start(8'h10, 3'd1);
    beat("t1 b0", 8'h10, 8'hA5, 1'b1);
    check("t1 busy", 32'(tx_busy), 32'd1);
    tick();
    check("t1 done", 32'(tx_done), 32'd1);
    check("t1 done w_notr", 32'(io_w_notr), 32'd0);
    tick();
    check("t1 done pulse", 32'(tx_done), 32'd0);
    check("t1 idle busy", 32'(tx_busy), 32'd0);

    // 2: four beats with address wrap
    for (int i = 0; i < 4; i++) write_slot(2'(i), slots[i]);
    start(8'hFE, 3'd4);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("t2 b%0d", i), 8'hFE + 8'(i), slots[i], i == 3);
      tick();
    end
    check("t2 done", 32'(tx_done), 32'd1);
    tick();

    // 3: rx preempts beat 2 for two cycles
    start(8'h40, 3'd4);
    beat("t3 b0", 8'h40, 8'h11, 1'b0);
    tick();
    beat("t3 b1", 8'h41, 8'h22, 1'b0);
    tick();
    io_rx_interrupt = 1'b1; dma_addr = 8'h80; dma_data = 8'h5A;
    #1;
    check("t3 pre1 w_notr", 32'(io_w_notr), 32'd0);
    tick();
    dma_addr = 8'h81; dma_data = 8'h5B;
    #1;
    check("t3 pre2 w_notr", 32'(io_w_notr), 32'd0);
    tick();
    io_rx_interrupt = 1'b0;
    #1;
    beat("t3 b2", 8'h42, 8'h33, 1'b0);
    tick();
    beat("t3 b3", 8'h43, 8'h44, 1'b1);
    tick();
    check("t3 done", 32'(tx_done), 32'd1);
    check("t3 no extra beat", 32'(io_w_notr), 32'd0);
    rx_head("t3 rx0", 8'h80, 8'h5A);
    rx_ready = 1'b1;
    tick();
    rx_head("t3 rx1", 8'h81, 8'h5B);
    tick();
    check("t3 rx empty", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // 4: overflow, then push+pop while full
    for (int k = 0; k < 4; k++) rx_push(8'h90 + 8'(k), 8'hC0 + 8'(k));
    check("t4 no ovf yet", 32'(rx_overflow), 32'd0);
    rx_push(8'h94, 8'hC4);
    check("t4 ovf", 32'(rx_overflow), 32'd1);
    rx_head("t4 head", 8'h90, 8'hC0);
    rx_ready = 1'b1;
    rx_push(8'h9F, 8'hCF);
    rx_head("t4 pp0", 8'h91, 8'hC1);
    tick();
    rx_head("t4 pp1", 8'h92, 8'hC2);
    tick();
    rx_head("t4 pp2", 8'h93, 8'hC3);
    tick();
    rx_head("t4 pp3", 8'h9F, 8'hCF);
    tick();
    check("t4 empty", 32'(rx_valid), 32'd0);
    check("t4 ovf sticky", 32'(rx_overflow), 32'd1);
    rx_ready = 1'b0;

    // 5: rejected lengths, start ignored during burst, staging frozen
    start(8'h20, 3'd0);
    check("t5 err len0", 32'(tx_err), 32'd1);
    check("t5 len0 w_notr", 32'(io_w_notr), 32'd0);
    tick();
    check("t5 err pulse", 32'(tx_err), 32'd0);
    start(8'h20, 3'd5);
    check("t5 err len5", 32'(tx_err), 32'd1);
    check("t5 len5 busy", 32'(tx_busy), 32'd0);
    start(8'h20, 3'd2);
    beat("t5 b0", 8'h20, 8'h11, 1'b0);
    tx_start = 1'b1; tx_base_addr = 8'h70; tx_len = 3'd1;
    write_slot(2'd0, 8'hEE);
    tx_start = 1'b0;
    check("t5 ignored err", 32'(tx_err), 32'd0);
    beat("t5 b1", 8'h21, 8'h22, 1'b1);
    tick();
    check("t5 done", 32'(tx_done), 32'd1);
    tick();

    // 6: async reset mid-burst, then a fresh burst
    start(8'h30, 3'd4);
    tick();
    tick();
    beat("t6 b2", 8'h32, 8'h33, 1'b0);
    rst = 1'b0;
    #1;
    check("t6 rst w_notr", 32'(io_w_notr), 32'd0);
    check("t6 rst busy", 32'(tx_busy), 32'd0);
    check("t6 rst tx_int", 32'(io_tx_interrupt), 32'd0);
    check("t6 rst ovf", 32'(rx_overflow), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    start(8'h55, 3'd1);
    beat("t6 new b0", 8'h55, 8'h11, 1'b1);
    tick();
    check("t6 done", 32'(tx_done), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
